pkt_replay_source: RTL

PKT_REPLAY_SOURCE -- requirements
Module: pkt_replay_source

---
 rtl/pkt_replay_source.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/pkt_replay_source.sv
// pkt_replay_source
//   Packet replay source. In IDLE, beats are written into a buffer. A start pulse
//   replays every stored beat, in order, on an Avalon-ST source with ready latency 0.
//   The buffer contents are kept after play, so each later start replays them again.
//
//   Optional feature: define PKT_REPLAY_MASK_EN to zero the low out_empty*8 bits of
//   out_data on eop beats. The valid bytes stay in the MSBs.
//
// Ports
//   clk, rst_n          single clock, asynchronous active-low reset
//   wr_en, wr_data,     load a beat (IDLE only); clear empties the buffer and wins
//   wr_eop, wr_empty,   over a simultaneous wr_en
//   clear
//   start, busy, done,  play pulse, state != IDLE, one-cycle completion pulse,
//   load_full           buffer holds DEPTH beats
//   beat_count          number of stored beats
//   pkt_sent            eop beats transferred (wraps at 16 bits)
//   out_*               Avalon-ST source: data, valid, ready, sop, eop, empty
module pkt_replay_source #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned E_WIDTH    = 6,
    parameter int unsigned DEPTH      = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic                       wr_eop,
    input  logic [E_WIDTH-1:0]         wr_empty,
    input  logic                       clear,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       load_full,
    output logic [$clog2(DEPTH):0]     beat_count,
    output logic [15:0]                pkt_sent,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_sop,
    output logic                       out_eop,
    output logic [E_WIDTH-1:0]         out_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {StIdle, StPlay, StDone} state_e;

    state_e                  state_q;
    logic [CW-1:0]           count_q;
    logic [CW-1:0]           count_next;
    // One bit wider than the address so it can reach count_q when every beat is read.
    logic [CW-1:0]           rd_ptr_q;
    // The next beat loaded into the output stage starts a packet.
    logic                    sop_pending_q;
    logic                    wr_fire;
    logic                    advance;
    logic                    more;
    logic [AW-1:0]           rd_idx;
    logic                    rd_eop;
    logic [E_WIDTH-1:0]      rd_empty;
    logic [DATA_WIDTH-1:0]   rd_data;

    logic [DATA_WIDTH-1:0]   data_mem  [DEPTH];
    logic                    eop_mem   [DEPTH];
    logic [E_WIDTH-1:0]      empty_mem [DEPTH];

    assign load_full  = (count_q == CW'(DEPTH));
    assign beat_count = count_q;
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);

    assign wr_fire = (state_q == StIdle) && wr_en && !clear && !load_full;

    always_comb begin
        count_next = count_q;
        if (clear) begin
            count_next = '0;
        end else if (wr_fire) begin
            count_next = count_q + CW'(1);
        end
    end

    // Buffer storage is not reset; its contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            data_mem[count_q[AW-1:0]]  <= wr_data;
            eop_mem[count_q[AW-1:0]]   <= wr_eop;
            empty_mem[count_q[AW-1:0]] <= wr_empty;
        end
    end

    // Read side of the beat at rd_ptr_q. The last stored beat always closes a packet.
    assign rd_idx   = rd_ptr_q[AW-1:0];
    assign rd_eop   = eop_mem[rd_idx] || ((rd_ptr_q + CW'(1)) == count_q);
    assign rd_empty = rd_eop ? empty_mem[rd_idx] : '0;

`ifdef PKT_REPLAY_MASK_EN
    localparam int NBYTES = int'(DATA_WIDTH / 8);

    always_comb begin
        rd_data = data_mem[rd_idx];
        if (rd_eop) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (i < int'(rd_empty)) begin
                    rd_data[i*8 +: 8] = 8'h00;
                end
            end
        end
    end
`else
    assign rd_data = data_mem[rd_idx];
`endif

    // The output stage may take a new beat when it is empty or its beat is accepted.
    assign advance = !out_valid || out_ready;
    assign more    = (rd_ptr_q < count_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            sop_pending_q <= 1'b0;
            pkt_sent      <= '0;
            out_data      <= '0;
            out_valid     <= 1'b0;
            out_sop       <= 1'b0;
            out_eop       <= 1'b0;
            out_empty     <= '0;
        end else begin
            if (out_valid && out_ready && out_eop) begin
                pkt_sent <= pkt_sent + 16'd1;
            end

            unique case (state_q)
                StIdle: begin
                    count_q <= count_next;
                    // start sees the count after this cycle's write or clear.
                    if (start) begin
                        if (count_next != '0) begin
                            state_q       <= StPlay;
                            rd_ptr_q      <= '0;
                            sop_pending_q <= 1'b1;
                        end else begin
                            state_q <= StDone;
                        end
                    end
                end

                StPlay: begin
                    if (advance) begin
                        if (more) begin
                            out_data      <= rd_data;
                            out_valid     <= 1'b1;
                            out_sop       <= sop_pending_q;
                            out_eop       <= rd_eop;
                            out_empty     <= rd_empty;
                            sop_pending_q <= rd_eop;
                            rd_ptr_q      <= rd_ptr_q + CW'(1);
                        end else begin
                            // Final beat has just been accepted.
                            out_valid <= 1'b0;
                            out_sop   <= 1'b0;
                            out_eop   <= 1'b0;
                            out_empty <= '0;
                            state_q   <= StDone;
                        end
                    end
                end

                StDone: begin
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
